// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared states, sync byte and bit-timing helper for the UART boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-FF synchronized 8N1 receiver with start-bit glitch rejection
module uart_rx_byte import boot_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  localparam logic [31:0] HALF = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] FULL = 32'(CLKS_PER_BIT - 1);
  rx_state_t   st;
  logic [1:0]  sync;
  logic        rx_q;
  logic [31:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  sh;
  // synchronize the line, time each bit and shift in data at bit centres
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
      st <= R_IDLE;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      o_byte <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], i_rx};
      rx_q <= sync[1];
      o_byte_valid <= 1'b0;
      o_frame_err <= 1'b0;
      case (st)
        R_IDLE: if (rx_q && !sync[1]) begin
          st <= R_START;
          cnt <= '0;
        end
        R_START: if (cnt == HALF) begin
          cnt <= '0;
          bitn <= '0;
          st <= sync[1] ? R_IDLE : R_DATA;
        end else cnt <= cnt + 1'b1;
        R_DATA: if (cnt == FULL) begin
          cnt <= '0;
          sh <= {sync[1], sh[7:1]};
          bitn <= bitn + 1'b1;
          if (bitn == 3'd7) st <= R_STOP;
        end else cnt <= cnt + 1'b1;
        default: if (cnt == FULL) begin
          cnt <= '0;
          o_byte <= sh;
          o_byte_valid <= 1'b1;
          o_frame_err <= !sync[1];
          st <= R_IDLE;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a checksummed program image from UART into instruction memory, then releases the core
module uart_boot_loader import boot_loader_pkg::*; #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 115200,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_core_rst_n,
  output logic                  o_done,
  output logic                  o_error
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LW = $clog2(LANES);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 2);
  state_t                state;
  logic [7:0]            rx_byte;
  logic                  byte_valid;
  logic                  frame_err;
  logic [15:0]           len_n;
  logic [15:0]           wcnt;
  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            csum;
  logic [31:0]           idle;
  logic                  active;
  logic [15:0]           len_next;
  logic [DATA_WIDTH-1:0] word_next;
  assign active = state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign len_next = {rx_byte, len_n[7:0]};
  assign word_next = {rx_byte, word[DATA_WIDTH-1:8]};
  uart_rx_byte #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ, BAUD))) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_byte      (rx_byte),
    .o_byte_valid(byte_valid),
    .o_frame_err (frame_err)
  );
  // loader FSM; the idle compare is offset so o_error lands TIMEOUT_CYCLES after the last byte_valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_SYNC;
      o_we <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      o_core_rst_n <= 1'b0;
      o_done <= 1'b0;
      o_error <= 1'b0;
      len_n <= '0;
      wcnt <= '0;
      lane <= '0;
      word <= '0;
      csum <= '0;
      idle <= '0;
    end else begin
      o_we <= 1'b0;
      idle <= (byte_valid || !active) ? '0 : idle + 1'b1;
      if (active && ((byte_valid && frame_err) || (!byte_valid && idle == TO_LAST))) begin
        state <= S_ERR;
        o_error <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_SYNC, S_ERR: if (!frame_err && rx_byte == SYNC_BYTE) begin
            state <= S_LEN0;
            o_error <= 1'b0;
            csum <= '0;
            wcnt <= '0;
            lane <= '0;
          end
          S_LEN0: begin
            len_n[7:0] <= rx_byte;
            csum <= csum ^ rx_byte;
            state <= S_LEN1;
          end
          S_LEN1: begin
            len_n[15:8] <= rx_byte;
            csum <= csum ^ rx_byte;
            wcnt <= '0;
            lane <= '0;
            if ({1'b0, len_next} > MAX_N) begin
              state <= S_ERR;
              o_error <= 1'b1;
            end else state <= (len_next == '0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            csum <= csum ^ rx_byte;
            word <= word_next;
            lane <= lane + 1'b1;
            if (lane == LW'(LANES - 1)) begin
              o_we <= 1'b1;
              o_addr <= wcnt[ADDR_WIDTH-1:0];
              o_wdata <= word_next;
              wcnt <= wcnt + 1'b1;
              if (wcnt == len_n - 1'b1) state <= S_CSUM;
            end
          end
          S_CSUM: if (rx_byte == csum) begin
            state <= S_DONE;
            o_done <= 1'b1;
            o_core_rst_n <= 1'b1;
          end else begin
            state <= S_ERR;
            o_error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench for the UART boot loader
module tb_uart_boot_loader;
  localparam int CPB = 10;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic        o_we, o_core_rst_n, o_done, o_error;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  wr_t         q[$];
  wr_t         e;
  logic [7:0]  fr[$];
  int          checks = 0, errors = 0, cyc = 0, last_bv = 0, exp_dly = 1;
  logic        pd = 1'b0, pe = 1'b0;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(1000)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_core_rst_n(o_core_rst_n), .o_done(o_done), .o_error(o_error)
  );

  always @(negedge clk) begin
    cyc++;
    if (o_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected addr %0d data %h", o_addr, o_wdata);
      end else begin
        e = q.pop_front();
        if ({o_addr, o_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, want addr %0d data %h", o_addr, o_wdata, e.a, e.d);
        end
      end
    end
    if (o_done && !pd) begin
      checks++;
      if (cyc - last_bv != exp_dly) begin
        errors++;
        $display("FAIL done_delay: got %0d cycles, want %0d", cyc - last_bv, exp_dly);
      end
    end
    if (o_error && !pe) begin
      checks++;
      if (cyc - last_bv != exp_dly) begin
        errors++;
        $display("FAIL error_delay: got %0d cycles, want %0d", cyc - last_bv, exp_dly);
      end
    end
    pd = o_done;
    pe = o_error;
    if (dut.byte_valid) last_bv = cyc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic state_chk(input string nm, input logic d, input logic er, input logic cr);
    chk({nm, "_flags"}, {61'd0, o_done, o_error, o_core_rst_n}, {61'd0, d, er, cr});
    chk({nm, "_pending"}, 64'(q.size()), 64'd0);
  endtask

  task automatic put(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendx(input logic [7:0] b, input logic stop);
    put(1'b0);
    for (int i = 0; i < 8; i++) put(b[i]);
    put(stop);
  endtask

  task automatic send_fr();
    foreach (fr[i]) sendx(fr[i], 1'b1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #23 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_two();
    q.push_back('{8'd0, 32'h00000013});
    q.push_back('{8'd1, 32'h00100093});
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset", {20'd0, o_we, o_addr, o_wdata, o_core_rst_n, o_done, o_error},  64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_two();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_fr();
    state_chk("normal", 1'b1, 1'b0, 1'b1);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h13};
    send_fr();
    state_chk("after_done", 1'b1, 1'b0, 1'b1);

    do_reset();
    push_two();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    send_fr();
    state_chk("bad_csum", 1'b0, 1'b1, 1'b0);
    push_two();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_fr();
    state_chk("retry", 1'b1, 1'b0, 1'b1);

    do_reset();
    fr = '{8'hA5, 8'h01, 8'h01, 8'h00};
    send_fr();
    state_chk("oversize", 1'b0, 1'b1, 1'b0);

    do_reset();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_fr();
    state_chk("zero_len", 1'b1, 1'b0, 1'b1);

    do_reset();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1 put(1'b0);
    rx = 1'b1;
    repeat (150) @(posedge clk);
    #1 state_chk("glitch", 1'b0, 1'b0, 1'b0);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_fr();
    sendx(8'h00, 1'b0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1 state_chk("frame_err", 1'b0, 1'b1, 1'b0);

    do_reset();
    exp_dly = 1000;
    fr = '{8'hA5, 8'h02, 8'h00};
    send_fr();
    repeat (500) @(posedge clk);
    #1 state_chk("pre_timeout", 1'b0, 1'b0, 1'b0);
    repeat (600) @(posedge clk);
    #1 state_chk("timeout", 1'b0, 1'b1, 1'b0);
    exp_dly = 1;

    do_reset();
    q.push_back('{8'd0, 32'h00000013});
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_fr();
    #3 rst_n = 1'b0;
    #1 chk("rst_mid", {20'd0, o_we, o_addr, o_wdata, o_core_rst_n, o_done, o_error}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 push_two();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_fr();
    state_chk("reload", 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
